// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply/divide unit producing HI/LO
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc;
  // Multiply: |A| (multiplicand). Divide: |B| (divisor).
  logic [WIDTH-1:0]   opnd;
  logic               op_div;
  logic               sign_pq;
  logic               sign_r;
  logic               dz;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign busy = (state != IDLE);

  // Per-iteration arithmetic and final sign application
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    prod_res  = sign_pq ? -acc : acc;
    quo_res   = sign_pq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_res   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; multiply wins when both starts are high, and a zero
  // divisor spends one DIV cycle before finishing without iterating
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_mult)     state_nx = MULT;
        else if (start_div) state_nx = DIV;
      end
      MULT: if (count == LAST) state_nx = FIN;
      DIV:  if (dz || count == LAST) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add / restoring-divide steps, result write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      sign_pq  <= 1'b0;
      sign_r   <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      HI_out   <= '0;
      LO_out   <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            count   <= '0;
            op_div  <= !start_mult;
            sign_pq <= A_in[WIDTH-1] ^ B_in[WIDTH-1];
            sign_r  <= A_in[WIDTH-1];
            dz      <= !start_mult && (B_in == '0);
            if (start_mult) begin
              opnd <= magnitude(A_in);
              acc  <= {{WIDTH{1'b0}}, magnitude(B_in)};
            end else begin
              opnd <= magnitude(B_in);
              acc  <= {{WIDTH{1'b0}}, magnitude(A_in)};
            end
          end
        end
        MULT: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + ONE;
        end
        DIV: begin
          if (!dz) begin
            if (div_ge) acc <= {div_diff, acc[WIDTH-2:0], 1'b1};
            else        acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end
          count <= count + ONE;
        end
        FIN: begin
          done <= 1'b1;
          if (dz) begin
            div_zero <= 1'b1;
          end else if (op_div) begin
            HI_out <= rem_res;
            LO_out <= quo_res;
          end else begin
            HI_out <= prod_res[2*WIDTH-1:WIDTH];
            LO_out <= prod_res[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
